// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of {pc, instr} entries between the RAM port and the consumer.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Qualify handshakes; a push into a full buffer only lands when a pop frees the slot.
  always_comb begin
    pop_ok_s  = pop & (count_r != '0);
    push_ok_s = push & ((count_r != CNT_W'(DEPTH)) | pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign empty     = (count_r == '0);
  assign full      = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, RAM read requests, redirect flush and
// in-order delivery of {pc, instr} to the instruction register.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000),
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               ir_en
);

  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0]  fetch_pc_r, fetch_pc_nxt_s;
  logic [ADDR_W-1:0]  resp_pc_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [ADDR_W-1:0]  redirect_tgt_s;
  logic               mem_req_r;
  logic [CNT_W-1:0]   outstanding_r, out_nxt_s;
  logic [CNT_W-1:0]   discard_r, discard_nxt_s;
  logic [CNT_W-1:0]   fifo_count_s, fifo_cnt_nxt_s;
  logic [CNT_W:0]     occ_nxt_s;
  logic               grant_s, pending_nxt_s, push_s, pop_s, issue_s;
  logic               fifo_empty_s, fifo_full_s;
  logic [ENTRY_W-1:0] head_s;

  // Next-state view of every counter, used both for state update and the issue decision.
  always_comb begin
    redirect_tgt_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    grant_s        = mem_req_r & mem_gnt;
    pending_nxt_s  = mem_req_r & ~mem_gnt;
    pop_s          = ~fifo_empty_s & instr_ready & ~redirect;
    push_s         = mem_rvalid & (discard_r == '0) & (~fifo_full_s | pop_s);
    out_nxt_s      = outstanding_r + CNT_W'(grant_s) - CNT_W'(mem_rvalid);

    if (redirect) begin
      fifo_cnt_nxt_s = '0;
      fetch_pc_nxt_s = redirect_tgt_s;
      discard_nxt_s  = out_nxt_s + CNT_W'(pending_nxt_s);
    end else begin
      fifo_cnt_nxt_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
      if (grant_s) begin
        fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(PC_INC);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (mem_rvalid && (discard_r != '0)) begin
        discard_nxt_s = discard_r - CNT_W'(1);
      end else begin
        discard_nxt_s = discard_r;
      end
    end

    if (redirect) begin
      if (discard_nxt_s != '0) begin
        state_nxt_s = FLUSH;
      end else if (fetch_en) begin
        state_nxt_s = FETCH;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = fetch_en ? FETCH : IDLE;
        FETCH:   state_nxt_s = (!fetch_en && !pending_nxt_s) ? IDLE : FETCH;
        FLUSH: begin
          if (discard_nxt_s != '0) begin
            state_nxt_s = FLUSH;
          end else begin
            state_nxt_s = fetch_en ? FETCH : IDLE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end

    // Everything that will land (in flight plus buffered) must fit before a new request goes out.
    occ_nxt_s = {1'b0, out_nxt_s} + {1'b0, fifo_cnt_nxt_s};
    issue_s   = (state_nxt_s == FETCH) && !pending_nxt_s &&
                (occ_nxt_s < (CNT_W+1)'(DEPTH));
  end

  // State, counters, PC and the registered request port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      discard_r     <= '0;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= RESET_PC;
    end else begin
      state_r       <= state_nxt_s;
      fetch_pc_r    <= fetch_pc_nxt_s;
      outstanding_r <= out_nxt_s;
      discard_r     <= discard_nxt_s;
      mem_req_r     <= pending_nxt_s | issue_s;
      if (issue_s) mem_addr_r <= fetch_pc_nxt_s;
      // The first surviving response after a redirect always belongs to the new target.
      if (redirect) begin
        resp_pc_r <= redirect_tgt_s;
      end else if (push_s) begin
        resp_pc_r <= resp_pc_r + ADDR_W'(PC_INC);
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({resp_pc_r, mem_rdata}),
    .pop       (pop_s),
    .flush     (redirect),
    .head_data (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = ~fifo_empty_s;
  assign instr_pc    = head_s[ENTRY_W-1:INSTR_W];
  assign instr_out   = head_s[INSTR_W-1:0];
  assign ir_en       = pop_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a RAM model with in-order responses and a
// queue of expected {pc, instr} words compared at every IR load.
module tb_instr_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, redirect, mem_gnt, mem_rvalid, instr_ready;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, instr_valid, ir_en;
  logic [31:0] mem_addr, instr_out, instr_pc;

  instr_fetch #(.ADDR_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .ir_en(ir_en)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  rsp_t        rsp_q[$];
  exp_t        exp_q[$];
  logic [31:0] grant_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_ins_log[$];

  int          checks = 0;
  int          errors = 0;
  int          grants;
  bit          en_v, gnt_v, rsp_en_v, ready_v, redir_v;
  logic [31:0] redir_tgt, exp_addr, held_addr;
  bit          hold_chk, stale_pending;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] plog(input int i);
    return (i < pop_pc_log.size()) ? pop_pc_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ilog(input int i);
    return (i < pop_ins_log.size()) ? pop_ins_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    en_v = 1'b0; gnt_v = 1'b0; rsp_en_v = 1'b0; ready_v = 1'b0; redir_v = 1'b0;
    redir_tgt = '0;
    rsp_q.delete(); exp_q.delete(); grant_log.delete();
    pop_pc_log.delete(); pop_ins_log.delete();
    exp_addr = RESET_PC; hold_chk = 1'b0; stale_pending = 1'b0; grants = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_mem_req"}, mem_req, 1'b0);
    check_eq({pfx, "_mem_addr"}, mem_addr, RESET_PC);
    check_eq({pfx, "_instr_valid"}, instr_valid, 1'b0);
    check_eq({pfx, "_instr_out"}, instr_out, 32'h0);
    check_eq({pfx, "_instr_pc"}, instr_pc, 32'h0);
    check_eq({pfx, "_ir_en"}, ir_en, 1'b0);
  endtask

  // One clock: observe at the falling edge, drive inputs, then model grant/pop/redirect.
  task automatic step();
    rsp_t r;
    exp_t e;
    bit   avail, exp_pop, granted;
    @(negedge clk);
    avail = (exp_q.size() != 0);
    check_eq("instr_valid", instr_valid, avail);
    check_eq("occupancy", (rsp_q.size() + exp_q.size() <= DEPTH), 1'b1);
    if (hold_chk) begin
      check_eq("req_hold", mem_req, 1'b1);
      check_eq("addr_hold", mem_addr, held_addr);
    end
    fetch_en = en_v; mem_gnt = gnt_v; instr_ready = ready_v;
    redirect = redir_v; redirect_pc = redir_tgt;
    if (rsp_en_v && rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = r.addr ^ 32'hA5A5_A5A5;
      if (!r.stale && !redir_v) begin
        e.pc = r.addr; e.instr = mem_rdata;
        exp_q.push_back(e);
      end
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
    granted = mem_req && mem_gnt;
    if (granted) begin
      if (stale_pending) begin
        r.stale = 1'b1;
        stale_pending = 1'b0;
      end else begin
        check_eq("mem_addr", mem_addr, exp_addr);
        exp_addr += 32'd4;
        r.stale = 1'b0;
      end
      r.addr = mem_addr;
      rsp_q.push_back(r);
      grant_log.push_back(mem_addr);
      grants++;
    end
    hold_chk  = mem_req && !mem_gnt;
    held_addr = mem_addr;
    exp_pop   = avail && ready_v && !redir_v;
    check_eq("ir_en", ir_en, exp_pop);
    if (exp_pop) begin
      e = exp_q.pop_front();
      pop_pc_log.push_back(instr_pc);
      pop_ins_log.push_back(instr_out);
      check_eq("instr_pc", instr_pc, e.pc);
      check_eq("instr_out", instr_out, e.instr);
    end
    if (redir_v) begin
      exp_q.delete();
      foreach (rsp_q[i]) rsp_q[i].stale = 1'b1;
      stale_pending = mem_req && !mem_gnt;
      exp_addr = {redir_tgt[31:2], 2'b00};
      redir_v  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    apply_reset();
    check_reset_outputs("reset");

    // Streaming with single-cycle RAM latency
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b1; ready_v = 1'b1;
    repeat (14) step();
    check_eq("t1_addr0", glog(0), 32'h0);
    check_eq("t1_addr1", glog(1), 32'h4);
    check_eq("t1_addr2", glog(2), 32'h8);
    check_eq("t1_addr3", glog(3), 32'hC);
    check_eq("t1_pc0", plog(0), 32'h0);
    check_eq("t1_pc1", plog(1), 32'h4);
    check_eq("t1_pc2", plog(2), 32'h8);
    check_eq("t1_ins0", ilog(0), 32'hA5A5_A5A5);
    check_eq("t1_ins1", ilog(1), 32'hA5A5_A5A1);
    check_eq("t1_ins2", ilog(2), 32'hA5A5_A5AD);

    // Consumer stall: issue stops at DEPTH, then resumes at 8
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b1; ready_v = 1'b0;
    repeat (8) step();
    check_eq("t2_grants", grants, 2);
    check_eq("t2_req_off", mem_req, 1'b0);
    ready_v = 1'b1;
    repeat (10) step();
    check_eq("t2_resume_addr", glog(2), 32'h8);
    check_eq("t2_pc0", plog(0), 32'h0);
    check_eq("t2_pc1", plog(1), 32'h4);
    check_eq("t2_pc2", plog(2), 32'h8);

    // Grant withheld: request holds, one grant counted
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b0; rsp_en_v = 1'b1; ready_v = 1'b1;
    repeat (5) step();
    gnt_v = 1'b1;
    step();
    gnt_v = 1'b0;
    repeat (3) step();
    check_eq("t3_grants", grants, 1);
    check_eq("t3_addr0", glog(0), 32'h0);
    gnt_v = 1'b1;
    repeat (6) step();

    // Redirect with two requests in flight
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b0; ready_v = 1'b1;
    repeat (5) step();
    check_eq("t4_inflight", grants, 2);
    grant_log.delete(); pop_pc_log.delete(); pop_ins_log.delete();
    redir_v = 1'b1; redir_tgt = 32'h0000_0103;
    step();
    rsp_en_v = 1'b1;
    repeat (10) step();
    check_eq("t4_addr", glog(0), 32'h100);
    check_eq("t4_pc", plog(0), 32'h100);
    check_eq("t4_ins", ilog(0), 32'hA5A5_A4A5);

    // PC wrap at the top of the address space
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b1; ready_v = 1'b1;
    redir_v = 1'b1; redir_tgt = 32'hFFFF_FFF8;
    step();
    repeat (8) step();
    check_eq("t5_addr0", glog(0), 32'hFFFF_FFF8);
    check_eq("t5_addr1", glog(1), 32'hFFFF_FFFC);
    check_eq("t5_addr2", glog(2), 32'h0000_0000);
    check_eq("t5_pc0", plog(0), 32'hFFFF_FFF8);

    // Asynchronous reset mid-cycle with a full buffer
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b1; ready_v = 1'b0;
    repeat (8) step();
    check_eq("t6_full_grants", grants, 2);
    check_eq("t6_full_valid", instr_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    apply_reset();
    en_v = 1'b1; gnt_v = 1'b1; rsp_en_v = 1'b1; ready_v = 1'b1;
    repeat (6) step();
    check_eq("t6_addr0", glog(0), RESET_PC);
    check_eq("t6_pc0", plog(0), RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
